// File: rtl/ram_fifo_flex.sv
// RAM-backed single-clock FIFO with standard or fall-through read mode, fill level, programmable
// almost flags and sticky errors; pushes are dropped when full and pops are ignored when empty.
module ram_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = 2**DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_out,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DEPTH:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [DEPTH:0] CAP    = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] AF_LVL = (DEPTH+1)'(AF_THRESH);
  localparam logic [DEPTH:0] AE_LVL = (DEPTH+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [2**DEPTH];

  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ov_q, ov_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             push_acc, pop_acc, load;
  logic [DEPTH:0]   ram_cnt;

  assign full         = (level_q == CAP);
  // In fall-through mode the output register, not the level, decides whether a word is poppable.
  assign empty        = FWFT ? !ov_q : (level_q == '0);
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign level        = level_q;
  assign rdata        = rdata_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    push_acc = shift_in && !full;
    pop_acc  = shift_out && !empty;
    ram_cnt  = level_q - (DEPTH+1)'(ov_q);
    load     = FWFT ? ((!ov_q || pop_acc) && (ram_cnt != '0)) : pop_acc;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    ov_d     = ov_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + DEPTH'(1);

    // Only words written at an earlier edge are counted in ram_cnt, so the read never races a write.
    if (load) begin
      rdata_d  = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + DEPTH'(1);
      ov_d     = FWFT;
    end else if (pop_acc) begin
      ov_d = 1'b0;
    end

    level_d     = level_q + (DEPTH+1)'(push_acc) - (DEPTH+1)'(pop_acc);
    overflow_d  = (overflow_q && !clr_err) || (shift_in && full);
    underflow_d = (underflow_q && !clr_err) || (shift_out && empty);
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rdata_q     <= '0;
      ov_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rdata_q     <= rdata_d;
      ov_q        <= ov_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_flex.sv
// Drives a standard-read and a fall-through instance with the same stimulus and checks each
// against its own queue-based reference.
module tb_ram_fifo_flex;

  logic       clk = 1'b0;
  logic       res_n;
  logic       shift_in, shift_out, clr_err;
  logic [7:0] wdata;

  logic [1:0][7:0] rdata_o;
  logic [1:0][3:0] level_o;
  logic [1:0]      full_o, empty_o, af_o, ae_o, ovf_o, unf_o;

  int total = 0;
  int bad   = 0;

  int         lvl [2];
  bit         ovf [2];
  bit         unf [2];
  logic [7:0] exp_rd [2];
  bit         ov1;
  int         rc1;
  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];

  always #5 clk = ~clk;

  ram_fifo_flex #(.WIDTH(8), .DEPTH(3), .FWFT(1'b0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
    .clk(clk), .res_n(res_n), .shift_in(shift_in), .wdata(wdata), .shift_out(shift_out),
    .rdata(rdata_o[0]), .full(full_o[0]), .empty(empty_o[0]), .almost_full(af_o[0]),
    .almost_empty(ae_o[0]), .level(level_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]),
    .clr_err(clr_err)
  );

  ram_fifo_flex #(.WIDTH(8), .DEPTH(3), .FWFT(1'b1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
    .clk(clk), .res_n(res_n), .shift_in(shift_in), .wdata(wdata), .shift_out(shift_out),
    .rdata(rdata_o[1]), .full(full_o[1]), .empty(empty_o[1]), .almost_full(af_o[1]),
    .almost_empty(ae_o[1]), .level(level_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]),
    .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_empty(input int m);
    return (m == 0) ? (lvl[0] == 0) : !ov1;
  endfunction

  task automatic reset_model();
    for (int m = 0; m < 2; m++) begin
      lvl[m] = 0; ovf[m] = 1'b0; unf[m] = 1'b0; exp_rd[m] = 8'h00;
    end
    ov1 = 1'b0;
    rc1 = 0;
    sb0.delete();
    sb1.delete();
  endtask

  // Applies one clock edge to both reference models using the inputs seen at that edge.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit emp, fl, pu, po, ld;
      emp = model_empty(m);
      fl  = (lvl[m] == 8);
      pu  = shift_in && !fl;
      po  = shift_out && !emp;
      ovf[m] = (ovf[m] && !clr_err) || (shift_in && fl);
      unf[m] = (unf[m] && !clr_err) || (shift_out && emp);
      if (m == 0) begin
        if (po) exp_rd[0] = sb0.pop_front();
        if (pu) sb0.push_back(wdata);
      end else begin
        ld = (!ov1 || po) && (rc1 > 0);
        if (po) void'(sb1.pop_front());
        if (ld) exp_rd[1] = sb1[0];
        if (ld) ov1 = 1'b1;
        else if (po) ov1 = 1'b0;
        if (pu) sb1.push_back(wdata);
        rc1 = rc1 - int'(ld) + int'(pu);
      end
      lvl[m] = lvl[m] + int'(pu) - int'(po);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d rdata", m), 32'(rdata_o[m]), 32'(exp_rd[m]));
      check($sformatf("m%0d level", m), 32'(level_o[m]), 32'(lvl[m]));
      check($sformatf("m%0d empty", m), 32'(empty_o[m]), 32'(model_empty(m)));
      check($sformatf("m%0d full", m), 32'(full_o[m]), 32'(lvl[m] == 8));
      check($sformatf("m%0d afull", m), 32'(af_o[m]), 32'(lvl[m] >= 6));
      check($sformatf("m%0d aempty", m), 32'(ae_o[m]), 32'(lvl[m] <= 2));
      check($sformatf("m%0d ovf", m), 32'(ovf_o[m]), 32'(ovf[m]));
      check($sformatf("m%0d unf", m), 32'(unf_o[m]), 32'(unf[m]));
    end
  endtask

  task automatic check_reset();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst m%0d rdata", m), 32'(rdata_o[m]), 32'h0);
      check($sformatf("rst m%0d level", m), 32'(level_o[m]), 32'h0);
      check($sformatf("rst m%0d empty", m), 32'(empty_o[m]), 32'h1);
      check($sformatf("rst m%0d full", m), 32'(full_o[m]), 32'h0);
      check($sformatf("rst m%0d afull", m), 32'(af_o[m]), 32'h0);
      check($sformatf("rst m%0d aempty", m), 32'(ae_o[m]), 32'h1);
      check($sformatf("rst m%0d ovf", m), 32'(ovf_o[m]), 32'h0);
      check($sformatf("rst m%0d unf", m), 32'(unf_o[m]), 32'h0);
    end
  endtask

  task automatic step(input logic si, input logic [7:0] wd, input logic so, input logic ce);
    shift_in = si; wdata = wd; shift_out = so; clr_err = ce;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    res_n = 1'b0; shift_in = 1'b0; shift_out = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    reset_model();
    #2;
    check_reset();
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;

    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf set", 32'(ovf_o[0]), 32'h1);
    check("ovf level", 32'(level_o[1]), 32'h8);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf clr", 32'(ovf_o[1]), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("unf set", 32'(unf_o[0]), 32'h1);
    check("unf level", 32'(level_o[1]), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    check("stream level", 32'(level_o[1]), 32'h4);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("fwft lvl N", 32'(level_o[1]), 32'h1);
    check("fwft empty N", 32'(empty_o[1]), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("fwft empty N+1", 32'(empty_o[1]), 32'h0);
    check("fwft rdata N+1", 32'(rdata_o[1]), 32'h3C);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("fwft gap", 32'(empty_o[1]), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("fwft gap end", 32'(rdata_o[1]), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    shift_in = 1'b0; shift_out = 1'b0;
    #2;
    res_n = 1'b0;
    #1;
    check_reset();
    reset_model();
    @(negedge clk);
    res_n = 1'b1;
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b1, 8'h9A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post rst empty", 32'(empty_o[0]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_flex.md
# ram_fifo_flex

Parametrised successor of the RAM-based FIFO: a single-clock, RAM-backed FIFO of 2**DEPTH words of WIDTH bits. It adds a selectable read mode (standard or first-word-fall-through), a fill-level output, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between producer and consumer blocks in the same clock domain and keeps the existing shift_in/shift_out handshake.

## Interface
- WIDTH, 8, data word width in bits.
- DEPTH, 8, log2 of capacity; capacity is 2**DEPTH words.
- FWFT, 0, 0 = standard read (data follows pop); 1 = first-word-fall-through (head word presented while empty=0).
- AF_THRESH, 2**DEPTH-2, almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- shift_in  in  1  push request; wdata is written if accepted.
- wdata  in  WIDTH  push data.
- shift_out  in  1  pop request.
- rdata  out  WIDTH  read data (registered).
- full  out  1  level == 2**DEPTH.
- empty  out  1  no word available to pop (see Operation).
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  DEPTH+1  words stored (accepted pushes minus accepted pops).
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.
- clr_err  in  1  clears overflow and underflow.

## Operation
- Storage: dual-pointer RAM of 2**DEPTH words; DEPTH-bit write/read pointers wrap modulo 2**DEPTH. RAM contents are not reset.
- Push accepted iff shift_in=1 and full=0. Pop accepted iff shift_out=1 and empty=0. Each is evaluated independently against flags of the current cycle.
- Simultaneous push and pop, neither flag set: both accepted, level unchanged.
- Full with shift_in and shift_out: pop accepted, push dropped, overflow set.
- Empty with shift_in and shift_out: push accepted, pop ignored, underflow set; FIFO state otherwise unaffected.
- Rejected push: data discarded, pointers/level unchanged. Rejected pop: rdata unchanged.
- overflow/underflow stay set until clr_err=1 at an edge; if a new error and clr_err coincide, the flag stays set.
- level width DEPTH+1 so 2**DEPTH is representable; almost_full/almost_empty/full derived from the registered level.
- FWFT=0: empty = (level == 0). Accepted pop at edge N loads rdata with the head word, visible after edge N.
- FWFT=1: an output register holds the head word; empty = output register invalid. The register loads from RAM at any edge where it is invalid or a pop is accepted, and RAM holds a word written at an earlier edge. A word written at edge N is readable from RAM from edge N+1. level still counts the output-register word.
- Reset (res_n=0, asynchronous): pointers 0, level 0, rdata 0, empty 1, full 0, almost_empty 1, almost_full 0 (unless AF_THRESH=0), overflow 0, underflow 0, output register invalid. Reset mid-operation discards all stored words.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Push at edge N: level, full, almost_* update after edge N. In FWFT=0, empty falls after edge N.
- FWFT=1, push into an empty FIFO at edge N: empty falls and rdata shows that word after edge N+1 (one cycle later than level).
- FWFT=1, pop at edge M with the next word in RAM: rdata shows the next word after edge M with empty low, giving back-to-back pops at one word per cycle.
- FWFT=1, pop at edge M of the only word while a push happens at M: empty is high for exactly one cycle, then falls after edge M+1.
- Error flags set after the offending edge.

## Test plan
Use WIDTH=8, DEPTH=3 (8 words), AF_THRESH=6, AE_THRESH=2, run for both FWFT=0 and FWFT=1.
- Reset, then push 0x01..0x08 on consecutive cycles -> level steps 1..8; almost_empty falls at level 3; almost_full rises at level 6; full rises at 8. Then pop 8 -> rdata 0x01..0x08 in order, empty at the end.
- Full FIFO, push 0xAA -> overflow=1, level stays 8, 0xAA never popped. Then clr_err pulse -> overflow=0 after that edge.
- Empty FIFO, shift_out and shift_in=0x55 in the same cycle -> underflow=1, level=1, next pop returns 0x55.
- Level 4, 20 cycles of simultaneous push/pop with incrementing data -> level stays 4, output order preserved, pointers wrap with no data corruption.
- FWFT=1, single push 0x3C into an empty FIFO at edge N -> level=1 after N; empty=0 and rdata=0x3C after N+1.
- Assert res_n=0 asynchronously mid-cycle with level 5 -> all outputs at their reset values before the next edge; a subsequent push/pop returns only new data.
